// File: rtl/rf_wr_delay_bypass_pkg.sv
// Shared helpers for the RF write-delay/bypass block: index-width function and
// the legal range of the write delay.
package rf_wr_delay_bypass_pkg;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 4;

    // Bits needed to encode n distinct values; never less than 1.
    function automatic int clogb2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/rf_wr_delay_bypass_if.sv
// Socket-side and RF-side signals of the write-delay/bypass block.
// master = socket/RF environment, slave = the delay block itself.
interface rf_wr_delay_bypass_if
    import rf_wr_delay_bypass_pkg::*;
#(
    parameter int data_width_g = 32,
    parameter int depth_g      = 16,
    parameter int latency_g    = 2
);
    localparam int OP_W   = clogb2(depth_g);
    localparam int PEND_W = clogb2(latency_g + 1);

    logic                    glock_in;
    logic                    wload_in;
    logic [OP_W-1:0]         wop_in;
    logic [data_width_g-1:0] wdata_in;
    logic                    rload_in;
    logic [OP_W-1:0]         rop_in;
    logic [data_width_g-1:0] rdata_out;
    logic                    rf_wload_out;
    logic [OP_W-1:0]         rf_wop_out;
    logic [data_width_g-1:0] rf_wdata_out;
    logic                    rf_rload_out;
    logic [OP_W-1:0]         rf_rop_out;
    logic [data_width_g-1:0] rf_rdata_in;
    logic [PEND_W-1:0]       pending_out;

    modport master (
        output glock_in, wload_in, wop_in, wdata_in, rload_in, rop_in, rf_rdata_in,
        input  rdata_out, rf_wload_out, rf_wop_out, rf_wdata_out,
               rf_rload_out, rf_rop_out, pending_out
    );

    modport slave (
        input  glock_in, wload_in, wop_in, wdata_in, rload_in, rop_in, rf_rdata_in,
        output rdata_out, rf_wload_out, rf_wop_out, rf_wdata_out,
               rf_rload_out, rf_rop_out, pending_out
    );

endinterface

// File: rtl/rf_wr_delay_bypass_stage.sv
// One {valid, op, data} write-delay stage with load enable and async reset.
module rf_wr_delay_bypass_stage #(
    parameter int op_w_g       = 4,
    parameter int data_width_g = 32
) (
    input  logic                    clk,
    input  logic                    rstx,
    input  logic                    en,
    input  logic                    valid_in,
    input  logic [op_w_g-1:0]       op_in,
    input  logic [data_width_g-1:0] data_in,
    output logic                    valid_out,
    output logic [op_w_g-1:0]       op_out,
    output logic [data_width_g-1:0] data_out
);

    logic                    valid_d, valid_q;
    logic [op_w_g-1:0]       op_d, op_q;
    logic [data_width_g-1:0] data_d, data_q;

    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        data_d  = data_q;
        if (en) begin
            valid_d = valid_in;
            op_d    = op_in;
            data_d  = data_in;
        end
    end

    always_ff @(posedge clk or negedge rstx) begin
        if (!rstx) begin
            valid_q <= 1'b0;
            op_q    <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            op_q    <= op_d;
            data_q  <= data_d;
        end
    end

    assign valid_out = valid_q;
    assign op_out    = op_q;
    assign data_out  = data_q;

endmodule

// File: rtl/rf_wr_delay_bypass.sv
// Delays RF writes by latency_g unlocked cycles and forwards in-flight data to the
// read port so the architectural write-to-read latency stays one cycle.
module rf_wr_delay_bypass
    import rf_wr_delay_bypass_pkg::*;
#(
    parameter int data_width_g = 32,
    parameter int depth_g      = 16,
    parameter int latency_g    = 2
) (
    input  logic                clk,
    input  logic                rstx,
    rf_wr_delay_bypass_if.slave bus
);

    localparam int OP_W   = clogb2(depth_g);
    localparam int PEND_W = clogb2(latency_g + 1);

    if (latency_g < LAT_MIN || latency_g > LAT_MAX) begin : g_lat_chk
        $error("rf_wr_delay_bypass: latency_g must be within 1..4");
    end

    logic                    adv;
    logic [latency_g-1:0]    valid_s;
    logic [OP_W-1:0]         op_s   [latency_g];
    logic [data_width_g-1:0] data_s [latency_g];

    assign adv = ~bus.glock_in;

    for (genvar k = 0; k < latency_g; k++) begin : g_stage
        if (k == 0) begin : g_head
            rf_wr_delay_bypass_stage #(.op_w_g(OP_W), .data_width_g(data_width_g)) u_stage (
                .clk(clk), .rstx(rstx), .en(adv),
                .valid_in(bus.wload_in), .op_in(bus.wop_in), .data_in(bus.wdata_in),
                .valid_out(valid_s[k]), .op_out(op_s[k]), .data_out(data_s[k])
            );
        end else begin : g_body
            rf_wr_delay_bypass_stage #(.op_w_g(OP_W), .data_width_g(data_width_g)) u_stage (
                .clk(clk), .rstx(rstx), .en(adv),
                .valid_in(valid_s[k-1]), .op_in(op_s[k-1]), .data_in(data_s[k-1]),
                .valid_out(valid_s[k]), .op_out(op_s[k]), .data_out(data_s[k])
            );
        end
    end

    // Oldest stage is scanned first so the youngest match overrides it; the last
    // stage still counts because the RF commits it only on the coming edge.
    logic [data_width_g-1:0] byp_data;
    always_comb begin
        byp_data = bus.rf_rdata_in;
        for (int k = latency_g - 1; k >= 0; k--) begin
            if (valid_s[k] && (op_s[k] == bus.rop_in)) byp_data = data_s[k];
        end
    end

    logic [PEND_W-1:0] pending_d, pending_q;
    always_comb begin
        pending_d = pending_q;
        if (adv) begin
            pending_d = PEND_W'(bus.wload_in);
            for (int k = 0; k < latency_g - 1; k++) begin
                pending_d = pending_d + PEND_W'(valid_s[k]);
            end
        end
    end

    always_ff @(posedge clk or negedge rstx) begin
        if (!rstx) pending_q <= '0;
        else       pending_q <= pending_d;
    end

    assign bus.rdata_out    = byp_data;
    assign bus.rf_wload_out = valid_s[latency_g-1] & adv;
    assign bus.rf_wop_out   = op_s[latency_g-1];
    assign bus.rf_wdata_out = data_s[latency_g-1];
    assign bus.rf_rload_out = bus.rload_in;
    assign bus.rf_rop_out   = bus.rop_in;
    assign bus.pending_out  = pending_q;

endmodule

// File: tb/tb_rf_wr_delay_bypass.sv
// Randomized bench for rf_wr_delay_bypass against an architectural model:
// a delay-line queue of issued writes, a committed RF image and the programmer-visible view.
module tb_rf_wr_delay_bypass;
    import rf_wr_delay_bypass_pkg::*;

    localparam int DW  = 32;
    localparam int DEP = 16;
    localparam int LAT = 2;

    typedef struct packed {
        logic       v;
        logic [3:0] op;
        logic [31:0] d;
    } wr_t;

    logic clk;
    logic rstx;

    rf_wr_delay_bypass_if #(.data_width_g(DW), .depth_g(DEP), .latency_g(LAT)) bus ();

    rf_wr_delay_bypass #(.data_width_g(DW), .depth_g(DEP), .latency_g(LAT)) dut (
        .clk(clk),
        .rstx(rstx),
        .bus(bus)
    );

    logic [31:0] mem  [DEP];   // what the RF really holds
    logic [31:0] arch [DEP];   // what a program should see
    wr_t         q[$];         // in-flight writes, youngest first

    int checks = 0;
    int errors = 0;

    assign bus.rf_rdata_in = mem[bus.rop_in];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int  n;
        logic exp_wl;
        n = 0;
        foreach (q[i]) if (q[i].v) n++;
        chk("rf_rload", 32'(bus.rf_rload_out), 32'(bus.rload_in));
        chk("rf_rop", 32'(bus.rf_rop_out), 32'(bus.rop_in));
        if (!rstx) begin
            chk("rst_rdata", bus.rdata_out, mem[bus.rop_in]);
            chk("rst_wload", 32'(bus.rf_wload_out), 32'd0);
            chk("rst_pending", 32'(bus.pending_out), 32'd0);
        end else begin
            exp_wl = (q.size() == LAT) && q[LAT-1].v && !bus.glock_in;
            chk("rdata", bus.rdata_out, arch[bus.rop_in]);
            chk("rf_wload", 32'(bus.rf_wload_out), 32'(exp_wl));
            chk("pending", 32'(bus.pending_out), 32'(n));
            if (exp_wl) begin
                chk("rf_wop", 32'(bus.rf_wop_out), 32'(q[LAT-1].op));
                chk("rf_wdata", bus.rf_wdata_out, q[LAT-1].d);
            end
        end
    endtask

    task automatic model_edge();
        wr_t e;
        if (!rstx) begin
            q.delete();
            foreach (arch[i]) arch[i] = mem[i];
        end else if (!bus.glock_in) begin
            if (q.size() == LAT) begin
                e = q.pop_back();
                if (e.v) mem[e.op] = e.d;
            end
            e.v  = bus.wload_in;
            e.op = bus.wop_in;
            e.d  = bus.wdata_in;
            q.push_front(e);
            if (bus.wload_in) arch[bus.wop_in] = bus.wdata_in;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_in(input logic w, input logic [3:0] wop, input logic [31:0] wd,
                          input logic [3:0] rop, input logic gl);
        bus.wload_in = w;
        bus.wop_in   = wop;
        bus.wdata_in = wd;
        bus.rload_in = 1'b1;
        bus.rop_in   = rop;
        bus.glock_in = gl;
    endtask

    initial begin
        foreach (mem[i]) begin
            mem[i]  = '0;
            arch[i] = '0;
        end
        rstx = 1'b0;
        set_in(1'b0, 4'd0, 32'd0, 4'd0, 1'b0);
        repeat (2) step();
        rstx = 1'b1;

        // fill both stages, then reset with them full
        set_in(1'b1, 4'd1, 32'h0000_1111, 4'd1, 1'b0); step();
        set_in(1'b1, 4'd2, 32'h0000_2222, 4'd2, 1'b0); step();
        rstx = 1'b0;
        set_in(1'b0, 4'd0, 32'd0, 4'd1, 1'b0); step();
        rstx = 1'b1;
        step();

        // r3 = A5, visible next cycle, committed two edges later
        set_in(1'b1, 4'd3, 32'h0000_00A5, 4'd3, 1'b0); step();
        set_in(1'b0, 4'd0, 32'd0, 4'd3, 1'b0);
        repeat (3) step();

        // youngest wins on r5
        set_in(1'b1, 4'd5, 32'h0000_0011, 4'd5, 1'b0); step();
        set_in(1'b1, 4'd5, 32'h0000_0022, 4'd5, 1'b0); step();
        set_in(1'b0, 4'd0, 32'd0, 4'd5, 1'b0);
        repeat (3) step();

        // two writes pending, glock for 3 cycles, then unlock
        set_in(1'b1, 4'd6, 32'hCAFE_0006, 4'd6, 1'b0); step();
        set_in(1'b1, 4'd8, 32'hCAFE_0008, 4'd8, 1'b0); step();
        set_in(1'b1, 4'd6, 32'hDEAD_DEAD, 4'd6, 1'b1); step();
        set_in(1'b0, 4'd0, 32'd0, 4'd8, 1'b1); step();
        set_in(1'b0, 4'd0, 32'd0, 4'd6, 1'b1); step();
        set_in(1'b0, 4'd0, 32'd0, 4'd6, 1'b0);
        repeat (3) step();

        // same-cycle write/read of r7
        set_in(1'b1, 4'd7, 32'h7777_7777, 4'd7, 1'b0); step();
        set_in(1'b0, 4'd0, 32'd0, 4'd7, 1'b0);
        repeat (3) step();

        // r9 = FF discarded by reset before commit
        set_in(1'b1, 4'd9, 32'h0000_00FF, 4'd9, 1'b0); step();
        rstx = 1'b0;
        set_in(1'b0, 4'd0, 32'd0, 4'd9, 1'b0); step();
        rstx = 1'b1;
        repeat (4) step();

        // randomized traffic with locks, collisions and occasional resets
        for (int c = 0; c < 600; c++) begin
            rstx = ($urandom_range(0, 99) != 0);
            set_in(1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 3)),
                   $urandom,
                   4'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 3)),
                   1'($urandom_range(0, 9) < 2));
            step();
        end
        rstx = 1'b1;
        set_in(1'b0, 4'd0, 32'd0, 4'd0, 1'b0);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
